// File: rtl/keccak_pkg.sv
// Shared Keccak constants, the inverse-chi row table and the inv_chi_seq FSM state type.
package keccak_pkg;

  localparam int LANE_W  = 64;
  localparam int LANE_N  = 25;
  localparam int PLANE_N = 5;
  localparam int PLANE_W = LANE_W * 5;
  localparam int STATE_W = LANE_W * LANE_N;
  localparam int CNT_W   = 3;

  // Index is the chi output row (bit x = lane x), entry is the chi input row.
  localparam logic [4:0] CHI_INV [32] = '{
    5'd0,  5'd11, 5'd22, 5'd9,  5'd13, 5'd4,  5'd18, 5'd15,
    5'd26, 5'd1,  5'd8,  5'd3,  5'd5,  5'd12, 5'd30, 5'd7,
    5'd21, 5'd20, 5'd2,  5'd23, 5'd16, 5'd17, 5'd6,  5'd19,
    5'd10, 5'd27, 5'd24, 5'd25, 5'd29, 5'd28, 5'd14, 5'd31
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [4:0] chi_row(input logic [4:0] a);
    logic [4:0] b;
    for (int x = 0; x < 5; x++)
      b[x] = a[x] ^ (~a[(x + 1) % 5] & a[(x + 2) % 5]);
    return b;
  endfunction

endpackage

// File: rtl/inv_chi_plane.sv
// Combinational inverse chi over one 5-lane plane: 64 independent 5-bit rows.
module inv_chi_plane
  import keccak_pkg::*;
(
  input  logic [PLANE_W-1:0] plane_in,
  output logic [PLANE_W-1:0] plane_out
);

  logic [4:0] row;
  logic [4:0] inv;

  always_comb begin
    plane_out = '0;
    row       = '0;
    inv       = '0;
    for (int z = 0; z < LANE_W; z++) begin
      for (int x = 0; x < 5; x++)
        row[x] = plane_in[x*LANE_W + z];
      inv = CHI_INV[row];
      for (int x = 0; x < 5; x++)
        plane_out[x*LANE_W + z] = inv[x];
    end
  end

endmodule

// File: rtl/inv_chi_seq.sv
// Sequential inverse-chi: one plane per cycle over five cycles.
// Optional forward-chi self-check of the result is enabled by INV_CHI_SELFCHECK_EN.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// in_ready is high only in IDLE and out_valid only in DONE, so the two never overlap.
module inv_chi_seq
  import keccak_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out,
  output logic               busy
`ifdef INV_CHI_SELFCHECK_EN
  ,
  output logic               check_err
`endif
);

  state_t             st;
  logic [CNT_W-1:0]   cnt;
  logic [STATE_W-1:0] in_q;
  logic [STATE_W-1:0] res_q;
  logic [PLANE_W-1:0] plane_in;
  logic [PLANE_W-1:0] plane_out;

  // Constant-index plane mux keeps out-of-range counts (only seen outside BUSY) harmless.
  always_comb begin
    plane_in = '0;
    for (int p = 0; p < PLANE_N; p++)
      if (cnt == CNT_W'(p))
        plane_in = in_q[p*PLANE_W +: PLANE_W];
  end

  inv_chi_plane u_plane (
    .plane_in  (plane_in),
    .plane_out (plane_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_q      <= '0;
      res_q     <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_q     <= state_in;
            cnt      <= '0;
            st       <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          for (int p = 0; p < PLANE_N; p++)
            if (cnt == CNT_W'(p))
              res_q[p*PLANE_W +: PLANE_W] <= plane_out;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(PLANE_N - 1)) begin
            st        <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            st        <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          st        <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign state_out = res_q;

`ifdef INV_CHI_SELFCHECK_EN
  logic [STATE_W-1:0] fwd;
  logic [4:0]         fwd_row;
  logic [4:0]         fwd_out;

  always_comb begin
    fwd     = '0;
    fwd_row = '0;
    fwd_out = '0;
    for (int y = 0; y < PLANE_N; y++) begin
      for (int z = 0; z < LANE_W; z++) begin
        for (int x = 0; x < 5; x++)
          fwd_row[x] = res_q[(5*y + x)*LANE_W + z];
        fwd_out = chi_row(fwd_row);
        for (int x = 0; x < 5; x++)
          fwd[(5*y + x)*LANE_W + z] = fwd_out[x];
      end
    end
  end

  assign check_err = (st == DONE) && (fwd != in_q);
`endif

endmodule

// File: tb/tb_inv_chi_seq.sv
// Directed and random bench for inv_chi_seq with an expected-result queue.
module tb_inv_chi_seq;

  localparam int SW = 1600;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] state_in;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] state_out;
  logic          busy;
`ifdef INV_CHI_SELFCHECK_EN
  logic          check_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [SW-1:0] exp_q[$];

  inv_chi_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
`ifdef INV_CHI_SELFCHECK_EN
    ,
    .check_err (check_err)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // forward chi straight from its row definition
  function automatic logic [SW-1:0] chi_state(input logic [SW-1:0] a);
    logic [SW-1:0] b;
    b = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        for (int z = 0; z < 64; z++)
          b[(x + 5*y)*64 + z] = a[(x + 5*y)*64 + z] ^
            (~a[((x + 1) % 5 + 5*y)*64 + z] & a[((x + 2) % 5 + 5*y)*64 + z]);
    return b;
  endfunction

  function automatic logic [SW-1:0] rand_state();
    logic [SW-1:0] s;
    for (int i = 0; i < SW/32; i++)
      s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    int lane;
    lane = 0;
    for (int i = 24; i >= 0; i--)
      if (obs[i*64 +: 64] !== exp[i*64 +: 64]) lane = i;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s lane %0d: observed %h expected %h", tag, lane,
             obs[lane*64 +: 64], exp[lane*64 +: 64]);
    end
  endtask

  // driver: offer din, expect result; returns at the negedge after the accepting edge
  task automatic send(input logic [SW-1:0] din, input logic [SW-1:0] expv);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    state_in = din;
    exp_q.push_back(expv);
    @(negedge clk);
    in_valid = 1'b0;
    state_in = ~din;
  endtask

  // monitor: wait for the result, check latency and data, optionally stall, then accept
  task automatic collect(input int hold);
    int k;
    logic [SW-1:0] e;
    check_val("busy", {31'd0, busy}, 32'd1);
    k = 0;
    while (!out_valid && k < 12) begin
      @(negedge clk);
      k++;
    end
    check_val("latency", k, 32'd5);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check_state("data", state_out, e);
`ifdef INV_CHI_SELFCHECK_EN
    check_val("check_err", {31'd0, check_err}, 32'd0);
`endif
    for (int h = 0; h < hold; h++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      state_in = rand_state();
      @(negedge clk);
      check_val("stall_valid", {31'd0, out_valid}, 32'd1);
      check_val("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check_state("stall_data", state_out, e);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("post_valid", {31'd0, out_valid}, 32'd0);
    check_val("post_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("post_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [SW-1:0] a;
    logic [SW-1:0] s;
    logic [SW-1:0] b2b [4];
    int acc [4];
    int k;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = '0;
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_state("rst_state_out", state_out, '0);
    rst = 1'b0;
    @(negedge clk);

    // zero state
    send('0, '0);
    collect(0);

    // all ones is a fixed point of chi
    send('1, '1);
    collect(0);

    // lanes 0 and 3 set in every plane: row 01001 inverts to lane 0 only
    s = '0;
    a = '0;
    for (int y = 0; y < 5; y++) begin
      s[(5*y)*64 +: 64]     = '1;
      s[(5*y + 3)*64 +: 64] = '1;
      a[(5*y)*64 +: 64]     = '1;
    end
    send(s, a);
    collect(0);

    // every table entry: lane x of each plane all ones when bit x of v is set
    for (int v = 0; v < 32; v++) begin
      a = '0;
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          if (v[x]) a[(5*y + x)*64 +: 64] = '1;
      send(chi_state(a), a);
      collect(0);
    end

    // random states, one with a long output stall and stray input pulses
    for (int r = 0; r < 4; r++) begin
      a = rand_state();
      send(chi_state(a), a);
      collect(r == 1 ? 10 : 0);
    end
    repeat (3) begin
      @(negedge clk);
      check_val("no_extra_valid", {31'd0, out_valid}, 32'd0);
    end

    // reset in the middle of BUSY (cnt = 2)
    a = rand_state();
    send(chi_state(a), a);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_state("abort_state_out", state_out, '0);
    void'(exp_q.pop_back());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check_val("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end
    a = rand_state();
    send(chi_state(a), a);
    collect(0);

    // back-to-back with both sides always willing
    for (int i = 0; i < 4; i++) b2b[i] = rand_state();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (!in_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      check_val("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      state_in = chi_state(b2b[i]);
      exp_q.push_back(b2b[i]);
      acc[i] = cyc;
      @(negedge clk);
      state_in = rand_state();
      if (i == 3) in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 12) begin
        @(negedge clk);
        k++;
      end
      check_val("b2b_latency", k, 32'd5);
      check_state("b2b_data", state_out, (exp_q.size() > 0) ? exp_q.pop_front() : '0);
      if (i > 0) check_val("b2b_period", acc[i] - acc[i-1], 32'd7);
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_val("b2b_idle", {31'd0, in_ready}, 32'd1);
    check_val("sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
